cfg_chain_loader: RTL

- Single-clock controller that loads a PE/tile configuration bitstream into the serial config_cell chain.
- Accepts config words from a host/DMA over valid/ready and serialises them one bit per enabled cycle into the chain head.
- Optionally recirculates the chain once to read it back, checking a CRC-16 of the returned bits against the CRC of the bits sent.
- Sits between the fabric config port and the head/tail of the PE config chain.

---
 rtl/cfg_chain_loader_pkg.sv | 30 +++
 rtl/cfg_chain_loader_if.sv | 28 ++
 rtl/cfg_chain_loader_crc16.sv | 30 +++
 rtl/cfg_chain_loader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cfg_chain_loader_pkg.sv
// Shared constants and helpers for the config-chain loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cfg_loader_pkg;

  // Loader FSM encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLR    = 3'd1;
  localparam logic [2:0] SHIFT  = 3'd2;
  localparam logic [2:0] VERIFY = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  // CRC-16-CCITT, serial MSB-first
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Number of input words needed to cover the whole chain
  function automatic int unsigned word_count(input int unsigned chain_len,
                                             input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // One serial CRC step for a single input bit
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Word stream from the host plus serial head/tail of the PE config chain.
// Latency: n/a (wires only).
// Backpressure: s_valid/s_ready handshake on the word stream; chain side has none.
interface cfg_chain_loader_if #(
  parameter int WORD_W = 32
);

  logic              s_valid;
  logic [WORD_W-1:0] s_data;
  logic              s_ready;
  logic              cfg_reset;
  logic              cfg_en;
  logic              cfg_bit;
  logic              cfg_ret;

  // Host/chain side: offers words and returns the chain tail
  modport master (
    output s_valid, s_data, cfg_ret,
    input  s_ready, cfg_reset, cfg_en, cfg_bit
  );

  // Loader side
  modport slave (
    input  s_valid, s_data, cfg_ret,
    output s_ready, cfg_reset, cfg_en, cfg_bit
  );

endinterface

// File: rtl/cfg_chain_loader_crc16.sv
// Serial CRC-16-CCITT accumulator, one bit per enabled cycle.
// Latency: crc_out reflects a bit one cycle after it is presented with en.
// Backpressure: none; en simply gates the update.
module crc16_serial
  import cfg_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc;

  // Restart from the init value on clr, otherwise fold in one bit per enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

  assign crc_out = crc;

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads a config bitstream into the serial PE config chain, optional CRC readback.
// Latency: 1 clear cycle + CHAIN_LEN shift cycles (+ CHAIN_LEN verify) + 1 done cycle.
// Backpressure: single-word buffer; s_ready drops while a word is still being shifted.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 100,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               verify_en,
  cfg_chain_loader_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned NWORDS = word_count(CHAIN_LEN, WORD_W);
  localparam int          IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int          WCNT_W = $clog2(NWORDS + 1);

  logic [2:0]        state;
  logic              verify_lat;
  logic              error_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] buf_dat;
  logic              buf_full;
  logic [IDX_W-1:0]  bit_idx;
  logic [WCNT_W-1:0] word_cnt;
  logic [15:0]       tx_crc;
  logic [15:0]       rx_crc;

  logic start_ok;
  logic shift_fire;
  logic chain_last;
  logic buf_last;
  logic ready;
  logic accept;
  logic in_verify;

  assign start_ok   = (state == IDLE) && start;
  assign in_verify  = (state == VERIFY);
  assign shift_fire = (state == SHIFT) && buf_full;
  assign chain_last = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  // The buffer drains either at the top bit of a word or at the last chain bit,
  // which is how the unused upper bits of the final word get discarded.
  assign buf_last   = (bit_idx == IDX_W'(WORD_W - 1)) || chain_last;
  assign ready      = ((state == CLR) || (state == SHIFT)) &&
                      (!buf_full || (shift_fire && buf_last)) &&
                      (word_cnt < WCNT_W'(NWORDS));
  assign accept     = bus.s_valid && ready;

  // Main sequencing: clear pulse, shift, optional recirculate, done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      verify_lat <= 1'b0;
      error_q    <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= CLR;
            verify_lat <= verify_en;
            error_q    <= 1'b0;
            bit_cnt    <= '0;
          end
        end
        CLR: state <= SHIFT;
        SHIFT: begin
          if (shift_fire) begin
            if (chain_last) begin
              bit_cnt <= '0;
              state   <= verify_lat ? VERIFY : DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        VERIFY: begin
          if (chain_last) begin
            bit_cnt <= '0;
            state   <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          if (verify_lat) error_q <= (tx_crc != rx_crc);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single-word buffer; a new word may land in the same cycle the old one drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_dat  <= '0;
      buf_full <= 1'b0;
      bit_idx  <= '0;
      word_cnt <= '0;
    end else if (start_ok) begin
      buf_full <= 1'b0;
      bit_idx  <= '0;
      word_cnt <= '0;
    end else if (accept) begin
      buf_dat  <= bus.s_data;
      buf_full <= 1'b1;
      bit_idx  <= '0;
      word_cnt <= word_cnt + 1'b1;
    end else if (shift_fire) begin
      if (buf_last) begin
        buf_full <= 1'b0;
        bit_idx  <= '0;
      end else begin
        buf_dat <= buf_dat >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  crc16_serial u_tx_crc (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_ok),
    .en      (shift_fire),
    .bit_in  (buf_dat[0]),
    .crc_out (tx_crc)
  );

  crc16_serial u_rx_crc (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_ok),
    .en      (in_verify),
    .bit_in  (bus.cfg_ret),
    .crc_out (rx_crc)
  );

  assign bus.s_ready   = ready;
  assign bus.cfg_reset = (state == CLR);
  assign bus.cfg_en    = shift_fire || in_verify;
  // During readback the tail is fed straight back to the head so the chain is restored
  assign bus.cfg_bit   = shift_fire ? buf_dat[0] : (in_verify ? bus.cfg_ret : 1'b0);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  // Mismatch is visible in the done cycle itself, then held by error_q
  assign error         = error_q | (done && verify_lat && (tx_crc != rx_crc));

endmodule
